// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared definitions for the single-port SRAM arbiter: requester indices,
//   counter widths, the response pipeline tag and a lowest-index picker.
//   Imported by sram_arb_wait_cnt and sram_port_arbiter.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    // Requester indices. A lower index means a higher fixed priority.
    localparam int REQ_MGMT  = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_FETCH = 2;
    localparam int NUM_REQ   = 3;

    // Starvation counter width. It covers MAX_WAIT values of 1..15.
    localparam int WAIT_W = 4;

    // Width of each statistics counter.
    localparam int STAT_W = 16;

    typedef logic [1:0] req_id_t;

    // One tag travels alongside each SRAM access. When it reaches stage 2,
    // the tag routes the response back to its requester.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    we;
    } rsp_tag_t;

    localparam rsp_tag_t TAG_IDLE = '0;

    // Returns a one-hot vector with only the lowest set bit of v kept.
    // It returns zero when v is zero.
    function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/sram_arb_wait_cnt.sv
// -----------------------------------------------------------------------------
// sram_arb_wait_cnt
//   Starvation counter for one requester. It counts consecutive cycles in
//   which the requester is valid but not granted, and saturates at MAX_WAIT.
//   It clears on a grant or when the request is withdrawn.
//   Ports:
//     clk, rst  clock, asynchronous active-low reset
//     valid     requester has a pending request
//     grant     requester was granted this cycle
//     starved   count has reached MAX_WAIT (requester is force-granted next)
// -----------------------------------------------------------------------------
module sram_arb_wait_cnt
    import sram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic grant,
    output logic starved
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    // NOTE: Sequential state uses non-blocking assignments, and reset is
    // asynchronous in the sensitivity list. Every reader therefore sees the
    // value from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!valid || grant) begin
            count <= '0;
        end else if (count < LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count >= LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port SRAM macro between three requesters:
//   mgmt (0), core data (1) and instruction fetch (2).
//   - Priority is fixed, lowest index first.
//   - A starvation guard force-grants any requester that has been denied
//     MAX_WAIT cycles in a row.
//   - At most one access is made per cycle.
//   - The SRAM pins are driven from registers.
//   - Each response comes back exactly 2 cycles after its grant, routed by
//     requester id.
//
//   Optional feature macro: SRAM_ARB_STATS_EN
//   - Enables 16-bit saturating per-requester wait statistics.
//   - Without the macro, stat_wait reads 0 and stat_clear is ignored.
//
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     req_valid    [3]       request pending; payload stable until granted
//     req_we       [3]       1 = write, 0 = read
//     req_mask     [3*MW]    byte write mask, requester i at [MW*i +: MW]
//     req_addr     [3*AW]    word address, requester i at [AW*i +: AW]
//     req_wdata    [3*DW]    write data, requester i at [DW*i +: DW]
//     req_grant    [3]       one-hot combinational accept
//     rsp_valid    [3]       one-hot response pulse
//     rsp_rdata    [DW]      read data (0 for a write acknowledge)
//     sram_csb     chip select, active-low
//     sram_web     write enable, active-low
//     sram_wmask   [MW]      byte mask
//     sram_addr    [AW]      word address
//     sram_din     [DW]      write data
//     sram_dout    [DW]      read data, valid the cycle after capture
//     stat_clear   clear statistics counters
//     stat_wait    [3*16]    per-requester wait statistics
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_mask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]                   req_grant,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 sram_csb,
    output logic                                 sram_web,
    output logic [DATA_WIDTH/8-1:0]              sram_wmask,
    output logic [ADDR_WIDTH-1:0]                sram_addr,
    output logic [DATA_WIDTH-1:0]                sram_din,
    input  logic [DATA_WIDTH-1:0]                sram_dout,
    input  logic                                 stat_clear,
    output logic [NUM_REQ*STAT_W-1:0]            stat_wait
);

    localparam int MASK_W = DATA_WIDTH / 8;

    // ---------------------------------------------------------------------
    // Starvation counters, one per requester
    // ---------------------------------------------------------------------
    logic [NUM_REQ-1:0] starved;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait
        sram_arb_wait_cnt #(
            .MAX_WAIT (MAX_WAIT)
        ) u_wait_cnt (
            .clk     (clk),
            .rst     (rst),
            .valid   (req_valid[i]),
            .grant   (req_grant[i]),
            .starved (starved[i])
        );
    end

    // ---------------------------------------------------------------------
    // Arbitration: a starved requester beats fixed priority. Among several
    // starved requesters, the lowest index wins.
    // ---------------------------------------------------------------------
    logic [NUM_REQ-1:0] forced;

    always_comb begin
        forced    = req_valid & starved;
        req_grant = (|forced) ? lowest_onehot(forced) : lowest_onehot(req_valid);
    end

    // ---------------------------------------------------------------------
    // Payload of the granted requester
    // ---------------------------------------------------------------------
    req_id_t                 sel_id;
    logic                    sel_we;
    logic [MASK_W-1:0]       sel_mask;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // NOTE: Every signal gets a default before the loop. Otherwise the
    // no-grant path would leave it unassigned and infer a latch.
    always_comb begin
        sel_id    = '0;
        sel_we    = 1'b0;
        sel_mask  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                sel_id    = req_id_t'(i);
                sel_we    = req_we[i];
                sel_mask  = req_mask[i*MASK_W +: MASK_W];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registered SRAM drive. On idle cycles the chip is deselected, and
    // addr/din/wmask hold their last values to avoid needless toggling.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else if (|req_grant) begin
            sram_csb   <= 1'b0;
            sram_web   <= ~sel_we;
            sram_wmask <= sel_mask;
            sram_addr  <= sel_addr;
            sram_din   <= sel_wdata;
        end else begin
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Response tag pipeline.
    //   Stage 1 is alongside the SRAM access (the cycle after the grant).
    //   Stage 2 is alongside sram_dout (two cycles after the grant).
    // ---------------------------------------------------------------------
    rsp_tag_t tag_s1;
    rsp_tag_t tag_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_s1 <= TAG_IDLE;
            tag_s2 <= TAG_IDLE;
        end else begin
            tag_s1 <= '{valid: |req_grant, id: sel_id, we: sel_we};
            tag_s2 <= tag_s1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_s2.valid && (tag_s2.id == req_id_t'(i));
        end
        // A write is acknowledged with zero data. The SRAM output is
        // undefined after a write cycle.
        if (tag_s2.valid && !tag_s2.we) begin
            rsp_rdata = sram_dout;
        end
    end

    // ---------------------------------------------------------------------
    // Optional wait statistics
    // ---------------------------------------------------------------------
`ifdef SRAM_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] stat_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stat_cnt <= '0;
            end else if (stat_clear) begin
                stat_cnt <= '0;
            end else if (req_valid[i] && !req_grant[i] && (stat_cnt != '1)) begin
                stat_cnt <= stat_cnt + 1'b1;
            end
        end

        assign stat_wait[i*STAT_W +: STAT_W] = stat_cnt;
    end
`else
    logic unused_stat_clear;

    assign unused_stat_clear = stat_clear;
    assign stat_wait         = '0;
`endif

endmodule
